// File: rtl/table_ram_writer.sv
// table_ram_writer
// Fills a DEPTH x DW table RAM with an address-derived pattern, reads every
// word back, and reports pass/fail, first failing address and a saturating
// mismatch count.
//
// Optional build macro: TABLE_RAM_WRITER_MANUAL_EN
//   When defined, i_write pulses in IDLE/DONE write i_data to a manual,
//   free-running address pointer. When undefined, i_write/i_data are ignored.
//
// Ports:
//   i_clk           system clock
//   i_rst           synchronous active-high reset
//   i_start         async key level; rising edge starts a run
//   i_write         async key level; manual write strobe (optional feature)
//   i_data          manual write data (optional feature)
//   o_ramAddress    RAM address
//   o_ramData       RAM write data
//   o_ramWren       RAM write enable
//   i_ramQ          RAM read data, valid READ_LATENCY clocks after its address
//   o_busy          high in FILL, VERIFY, DRAIN
//   o_done          high in DONE
//   o_pass          high in DONE when no mismatch was seen
//   o_errorAddress  first mismatching address
//   o_errorCount    mismatch count, saturating at all-ones
module table_ram_writer #(
  parameter int              DEPTH        = 1024,
  parameter int              AW           = 10,
  parameter int              DW           = 10,
  parameter logic [DW-1:0]   SEED         = DW'(10'h155),
  parameter int              READ_LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_write,
  input  logic [DW-1:0] i_data,
  output logic [AW-1:0] o_ramAddress,
  output logic [DW-1:0] o_ramData,
  output logic          o_ramWren,
  input  logic [DW-1:0] i_ramQ,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [AW-1:0] o_errorAddress,
  output logic [AW-1:0] o_errorCount
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CNT_MAX   = {AW{1'b1}};
  localparam logic [1:0]    DRAIN_END = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Fill pattern: address zero-extended or truncated to DW bits, XOR seed.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [AW+DW-1:0] ext;
    ext = {{DW{1'b0}}, a};
    return ext[DW-1:0] ^ SEED;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    drain_cnt_q, drain_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wren_q, wren_d;
  logic          issue_vld_q, issue_vld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [AW-1:0] err_count_q, err_count_d;

  logic [1:0]    start_sync_q;
  logic          start_prev_q;
  logic          start_pulse_s;

  // Read-tag pipeline: entry READ_LATENCY-1 lines up with i_ramQ.
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [AW-1:0]           pipe_addr_q [READ_LATENCY];
  logic                    cmp_vld_s;
  logic [AW-1:0]           cmp_addr_s;

  assign start_pulse_s = start_sync_q[1] & ~start_prev_q;
  assign cmp_vld_s     = pipe_vld_q[READ_LATENCY-1];
  assign cmp_addr_s    = pipe_addr_q[READ_LATENCY-1];

`ifdef TABLE_RAM_WRITER_MANUAL_EN
  logic [1:0]    write_sync_q;
  logic          write_prev_q;
  logic          write_pulse_s;
  logic [AW-1:0] man_ptr_q, man_ptr_d;

  assign write_pulse_s = write_sync_q[1] & ~write_prev_q;

  // Write-key synchronizer, edge detector and manual address pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      write_sync_q <= 2'b00;
      write_prev_q <= 1'b0;
      man_ptr_q    <= ADDR_ZERO;
    end else begin
      write_sync_q <= {write_sync_q[0], i_write};
      write_prev_q <= write_sync_q[1];
      man_ptr_q    <= man_ptr_d;
    end
  end
`else
  logic unused_inputs_s;
  assign unused_inputs_s = ^{i_write, i_data};
`endif

  // Start-key synchronizer and edge detector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], i_start};
      start_prev_q <= start_sync_q[1];
    end
  end

  // Shift the read tags alongside the RAM's read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_vld_q <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_addr_q[i] <= ADDR_ZERO;
      end
    end else begin
      pipe_vld_q[0]  <= issue_vld_q;
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  // Next-state, pointer, compare and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    drain_cnt_d = drain_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    issue_vld_d = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
`ifdef TABLE_RAM_WRITER_MANUAL_EN
    man_ptr_d   = man_ptr_q;
`endif

    // Compare first so a start pulse below can still clear the results.
    if (cmp_vld_s && (i_ramQ != pattern(cmp_addr_s))) begin
      if (err_count_q == ADDR_ZERO) begin
        err_addr_d = cmp_addr_s;
      end else begin
        err_addr_d = err_addr_q;
      end
      if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + ADDR_ONE;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_count_d = err_count_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_pulse_s) begin
          state_d     = ST_FILL;
          ptr_d       = ADDR_ZERO;
          err_addr_d  = ADDR_ZERO;
          err_count_d = ADDR_ZERO;
        end
`ifdef TABLE_RAM_WRITER_MANUAL_EN
        else if (write_pulse_s) begin
          wren_d    = 1'b1;
          addr_d    = man_ptr_q;
          data_d    = i_data;
          man_ptr_d = (man_ptr_q == ADDR_LAST) ? ADDR_ZERO : man_ptr_q + ADDR_ONE;
        end
`endif
        else begin
          state_d = state_q;
        end
      end
      ST_FILL: begin
        wren_d = 1'b1;
        addr_d = ptr_q;
        data_d = pattern(ptr_q);
        if (ptr_q == ADDR_LAST) begin
          ptr_d   = ADDR_ZERO;
          state_d = ST_VERIFY;
        end else begin
          ptr_d = ptr_q + ADDR_ONE;
        end
      end
      ST_VERIFY: begin
        addr_d      = ptr_q;
        issue_vld_d = 1'b1;
        if (ptr_q == ADDR_LAST) begin
          ptr_d       = ADDR_ZERO;
          drain_cnt_d = 2'd0;
          state_d     = ST_DRAIN;
        end else begin
          ptr_d = ptr_q + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        // The address register adds one cycle ahead of the RAM latency, so
        // the last compare lands on the edge that enters DONE.
        if (drain_cnt_q == DRAIN_END) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_VERIFY) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_count_d == ADDR_ZERO);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ADDR_ZERO;
      drain_cnt_q <= 2'd0;
      addr_q      <= ADDR_ZERO;
      data_q      <= {DW{1'b0}};
      wren_q      <= 1'b0;
      issue_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_addr_q  <= ADDR_ZERO;
      err_count_q <= ADDR_ZERO;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      drain_cnt_q <= drain_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      issue_vld_q <= issue_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign o_ramAddress   = addr_q;
  assign o_ramData      = data_q;
  assign o_ramWren      = wren_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_pass         = pass_q;
  assign o_errorAddress = err_addr_q;
  assign o_errorCount   = err_count_q;

endmodule

// File: tb/tb_table_ram_writer.sv
// Directed bench for table_ram_writer with DEPTH=16. Instance dut uses a
// 1-cycle RAM model with per-address fault injection; instance dut2 uses a
// 2-cycle RAM model.
module tb_table_ram_writer;

  localparam int            DEPTH = 16;
  localparam int            AW    = 4;
  localparam int            DW    = 10;
  localparam logic [DW-1:0] SEED  = 10'h155;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 (READ_LATENCY = 1)
  logic          rst, start, wr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren, busy, done, pass;
  logic [AW-1:0] err_addr, err_cnt;
  logic [DW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] fault_mask;

  // Instance 2 (READ_LATENCY = 2)
  logic          rst2, start2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] data2, q2a, q2;
  logic          wren2, busy2, done2, pass2;
  logic [AW-1:0] erra2, errc2;
  logic [DW-1:0] mem2 [DEPTH];

  table_ram_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SEED(SEED), .READ_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_write(wr), .i_data(wdata),
    .o_ramAddress(ram_addr), .o_ramData(ram_data), .o_ramWren(ram_wren), .i_ramQ(ram_q),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_errorAddress(err_addr), .o_errorCount(err_cnt));

  table_ram_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SEED(SEED), .READ_LATENCY(2)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_write(1'b0), .i_data(10'h000),
    .o_ramAddress(addr2), .o_ramData(data2), .o_ramWren(wren2), .i_ramQ(q2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_errorAddress(erra2), .o_errorCount(errc2));

  // Synchronous RAM, 1-cycle read, bit 0 flipped on faulted addresses.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr] ^ (fault_mask[ram_addr] ? 10'h001 : 10'h000);
  end

  // Synchronous RAM, 2-cycle read.
  always @(posedge clk) begin
    if (wren2) mem2[addr2] <= data2;
    q2a <= mem2[addr2];
    q2  <= q2a;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] av;
    av = DW'(a);
    return av ^ SEED;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the first write, then expects exactly DEPTH back-to-back writes.
  task automatic check_fill(input string tag);
    int k;
    k = 0;
    while (!ram_wren && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({tag, " fill start"}, {31'd0, ram_wren}, 32'd1);
    check({tag, " busy in fill"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check({tag, " fill wren"}, {31'd0, ram_wren}, 32'd1);
      check({tag, " fill addr"}, {28'd0, ram_addr}, i);
      check({tag, " fill data"}, {22'd0, ram_data}, {22'd0, pat(i)});
      if (i == 5) check({tag, " P(5)"}, {22'd0, ram_data}, 32'h150);
      @(negedge clk);
    end
    check({tag, " fill end"}, {31'd0, ram_wren}, 32'd0);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done reached"}, {31'd0, done}, 32'd1);
    check({tag, " busy low at done"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        exp_pass;
    logic [3:0]  exp_eaddr;
    logic [3:0]  exp_ecnt;
  } scen_t;

  scen_t sc [6];

  initial begin
    int cyc, k, wcnt;
    logic flag;

    sc[0] = '{16'h1080, 1'b0, 4'd7,  4'd2};   // faults at 7 and 12
    sc[1] = '{16'h0000, 1'b1, 4'd0,  4'd0};   // clean rerun clears results
    sc[2] = '{16'h0001, 1'b0, 4'd0,  4'd1};   // first address
    sc[3] = '{16'h8000, 1'b0, 4'd15, 4'd1};   // last address, needs drain
    sc[4] = '{16'hFFFF, 1'b0, 4'd0,  4'd15};  // 16 mismatches saturate at 15
    sc[5] = '{16'hC000, 1'b0, 4'd14, 4'd2};

    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; wr = 1'b0;
    wdata = 10'h000; fault_mask = 16'h0000;
    repeat (4) @(negedge clk);
    check("reset outputs", {ram_wren, busy, done, pass, err_addr, err_cnt, ram_addr, ram_data},
          32'd0);
    rst = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk);
    check("idle outputs", {ram_wren, busy, done, pass, err_addr, err_cnt, ram_addr, ram_data},
          32'd0);

`ifdef TABLE_RAM_WRITER_MANUAL_EN
    wdata = 10'h3FF;
    for (int w = 0; w < 2; w++) begin
      wr = 1'b1;
      repeat (3) @(negedge clk);
      wr = 1'b0;
      k = 0;
      while (!ram_wren && k < 10) begin @(negedge clk); k++; end
      check("manual wren", {31'd0, ram_wren}, 32'd1);
      check("manual addr", {28'd0, ram_addr}, w);
      check("manual data", {22'd0, ram_data}, 32'h3FF);
      @(negedge clk);
      check("manual single cycle", {31'd0, ram_wren}, 32'd0);
    end
    start = 1'b1; wr = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; wr = 1'b0;
    check_fill("run1");
`else
    wdata = 10'h3FF;
    wr = 1'b1;
    repeat (3) @(negedge clk);
    wr = 1'b0;
    flag = 1'b0;
    repeat (6) begin
      if (ram_wren) flag = 1'b1;
      @(negedge clk);
    end
    check("write ignored", {31'd0, flag}, 32'd0);
    pulse_start();
    check_fill("run1");
`endif
    wait_done("run1", cyc);
    check("run1 latency", 16 + cyc, 33);
    check("run1 pass", {31'd0, pass}, 32'd1);
    check("run1 errcnt", {28'd0, err_cnt}, 32'd0);

    // Fault scenarios, each restarted from DONE
    for (int s = 0; s < 6; s++) begin
      fault_mask = sc[s].mask;
      pulse_start();
      check($sformatf("sc%0d busy", s), {31'd0, busy}, 32'd1);
      wait_done($sformatf("sc%0d", s), cyc);
      check($sformatf("sc%0d pass", s), {31'd0, pass}, {31'd0, sc[s].exp_pass});
      check($sformatf("sc%0d erraddr", s), {28'd0, err_addr}, {28'd0, sc[s].exp_eaddr});
      check($sformatf("sc%0d errcnt", s), {28'd0, err_cnt}, {28'd0, sc[s].exp_ecnt});
    end
    fault_mask = 16'h0000;

    // Start pulse during VERIFY at address 4 is ignored
    pulse_start();
    k = 0;
    while (!(busy && !ram_wren && ram_addr == 4'd4) && k < 100) begin @(negedge clk); k++; end
    check("verify addr4 reached", {31'd0, (k < 100)}, 32'd1);
    pulse_start();
    wait_done("vstart", cyc);
    check("vstart pass", {31'd0, pass}, 32'd1);
    flag = 1'b0;
    repeat (40) begin
      if (ram_wren || busy || !done) flag = 1'b1;
      @(negedge clk);
    end
    check("vstart single run", {31'd0, flag}, 32'd0);

    // Reset in the middle of FILL
    pulse_start();
    k = 0;
    while (!(ram_wren && ram_addr == 4'd9) && k < 40) begin @(negedge clk); k++; end
    check("fill addr9 reached", {31'd0, (k < 40)}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun reset wren", {31'd0, ram_wren}, 32'd0);
    check("midrun reset outputs", {ram_wren, busy, done, pass, err_addr, err_cnt, ram_addr, ram_data},
          32'd0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    check_fill("after reset");
    wait_done("after reset", cyc);
    check("after reset pass", {31'd0, pass}, 32'd1);

    // READ_LATENCY = 2 instance
    start2 = 1'b1;
    repeat (3) @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!wren2 && k < 12) begin @(negedge clk); k++; end
    check("rl2 fill start", {31'd0, wren2}, 32'd1);
    check("rl2 first addr", {28'd0, addr2}, 32'd0);
    cyc = 0; wcnt = 0;
    while (!done2 && cyc < 200) begin
      if (wren2) wcnt++;
      @(negedge clk);
      cyc++;
    end
    check("rl2 latency", cyc, 34);
    check("rl2 write count", wcnt, 16);
    check("rl2 pass", {31'd0, pass2}, 32'd1);
    check("rl2 errcnt", {28'd0, errc2}, 32'd0);
    check("rl2 busy low", {31'd0, busy2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/table_ram_writer.md
Name: table_ram_writer

Overview:
Writer and self-check engine for the 1024 x 10 on-chip table RAM that the switch-addressed display path reads.
- On a start key, fills every RAM location with a deterministic address-derived pattern.
- Reads every location back and compares it against the same pattern.
- Reports pass/fail, the first failing address and a saturating mismatch count, for display on the 7-segment digits.

Parameters:
DEPTH, 1024, number of RAM words; power of two, minimum 4
AW, 10, address width; equals log2(DEPTH)
DW, 10, data width
SEED, 10'h155, XOR seed of the fill pattern; DW bits wide
READ_LATENCY, 1, clocks from address presented to valid i_ramQ; legal values 1 or 2

Ports:
i_clk  in  1  system clock (CLOCK_50)
i_rst  in  1  synchronous, active-high reset
i_start  in  1  asynchronous level from a key; its rising edge starts a run
i_write  in  1  asynchronous level from a key; manual write strobe (used only with the optional feature)
i_data  in  DW  manual write data from the switches (used only with the optional feature)
o_ramAddress  out  AW  RAM address
o_ramData  out  DW  RAM write data
o_ramWren  out  1  RAM write enable
i_ramQ  in  DW  RAM read data, valid READ_LATENCY clocks after its address
o_busy  out  1  high in FILL, VERIFY and DRAIN
o_done  out  1  high in DONE
o_pass  out  1  high in DONE when the mismatch count is 0
o_errorAddress  out  AW  address of the first mismatch
o_errorCount  out  AW  mismatch count, saturating at all-ones

Behaviour:
- All outputs are registered. On reset every output is 0 and the FSM is in IDLE. The reset clears the synchronizers, the edge detectors and the address pointer.
- i_start and i_write each pass through a 2-flop synchronizer. A rising edge on the synchronized level yields a 1-cycle pulse.
- Fill pattern: P(a) = zero-extend-or-truncate(a to DW bits) XOR SEED. With AW=DW=10, P(5)=0x150.
- States and transitions:
  - IDLE: wait. On a start pulse go to FILL; clear o_errorCount and o_errorAddress; set the pointer to 0.
  - FILL: each cycle drive o_ramWren=1, o_ramAddress=ptr, o_ramData=P(ptr), then increment ptr. After address DEPTH-1 is written, wrap ptr to 0 and go to VERIFY.
    - Exactly DEPTH consecutive write cycles, no gaps.
  - VERIFY: o_ramWren=0. Issue one read per cycle, addresses 0..DEPTH-1.
    - A valid/address shift pipeline of depth READ_LATENCY tags each returning i_ramQ with its address.
    - On a mismatch, increment o_errorCount (saturating). If the count was 0, capture o_errorAddress.
    - After the last address is issued, go to DRAIN.
  - DRAIN: hold for READ_LATENCY cycles so the last compares complete, then go to DONE.
  - DONE: o_done=1, o_pass=(o_errorCount==0). Results hold. A start pulse behaves as in IDLE and begins a new run.
- A start pulse during FILL, VERIFY or DRAIN is ignored.
- Reset mid-run: at the clock edge sampling i_rst high, the FSM returns to IDLE and o_ramWren drops. A partial fill is not completed.
- o_busy, o_done and o_pass are mutually consistent: o_busy and o_done are never both high.

Optional Feature:
Macro TABLE_RAM_WRITER_MANUAL_EN.
- Defined: in IDLE or DONE, each i_write pulse performs one cycle with o_ramWren=1, o_ramAddress=manual pointer, o_ramData=i_data.
  - The manual pointer then increments and wraps from DEPTH-1 to 0.
  - The pointer resets to 0 and is not affected by fill runs.
  - If a start pulse and a write pulse occur in the same cycle, start wins and the write is dropped.
  - A write pulse while busy is ignored.
- Undefined: i_write and i_data are ignored, no manual pointer logic is built, and o_ramWren is high only in FILL.

Test Plan:
- DEPTH=16, SEED=0x155, ideal RAM model, READ_LATENCY=1. Start pulse -> 16 consecutive wren cycles at addr 0..15 with data P(a), e.g. addr 5 = 0x150. Then o_done=1, o_pass=1, o_errorCount=0.
- Same setup; the RAM model returns data XOR 1 at addr 7 and addr 12 -> o_errorAddress=7, o_errorCount=2, o_pass=0.
- READ_LATENCY=2 with a 2-cycle RAM model -> run passes. Total cycles from entering FILL to o_done is 16 + 16 + 2.
- Assert i_rst at addr 9 of FILL -> next cycle o_ramWren=0 and all outputs are 0. A later start runs a full pass from addr 0.
- Start pulse at VERIFY addr 4 -> ignored; the run completes once, o_done=1.
- With TABLE_RAM_WRITER_MANUAL_EN, in IDLE: i_data=0x3FF, then two write pulses -> writes 0x3FF to addr 0 and addr 1. Start and write pulses in the same cycle -> no manual write; FILL begins.
